// File: rtl/hski_heap_responder_if.sv
// Request/response handshake bundle between the SKI step pipeline (master)
// and the heap responder (slave).
interface hski_heap_responder_if;
  logic [94:0] req_i1;
  logic        req_ready_o;
  logic [64:0] rsp_o;
  logic        rsp_ready_i2;

  modport master (
    output req_i1,
    output rsp_ready_i2,
    input  req_ready_o,
    input  rsp_o
  );

  modport slave (
    input  req_i1,
    input  rsp_ready_i2,
    output req_ready_o,
    output rsp_o
  );
endinterface

// File: rtl/hski_heap_responder.sv
// Heap cell responder: read / write / allocate on a single-port cell RAM with a
// registered valid/ready response. Optional bounds checking: HSKI_HEAP_BOUNDS_CHECK_EN.
module hski_heap_responder #(
  parameter int HEAP_LOG2  = 10,
  parameter int ALLOC_BASE = 1
) (
  input  logic                 system1000,
  input  logic                 system1000_rstn,
  hski_heap_responder_if.slave bus,
  output logic [HEAP_LOG2:0]   alloc_count_o,
  output logic                 err_o
);

  localparam int DEPTH = 1 << HEAP_LOG2;
  localparam logic [HEAP_LOG2:0] ALLOC_BASE_CNT = (HEAP_LOG2+1)'(ALLOC_BASE);
  localparam logic [HEAP_LOG2:0] DEPTH_CNT      = (HEAP_LOG2+1)'(DEPTH);
  localparam logic [HEAP_LOG2:0] ONE_CNT        = (HEAP_LOG2+1)'(1);
  localparam logic [1:0] TAG_NONE  = 2'b00;
  localparam logic [1:0] TAG_RD    = 2'b01;
  localparam logic [1:0] TAG_WR    = 2'b10;
  localparam logic [1:0] TAG_ALLOC = 2'b11;
  localparam logic [63:0] ALL_ONES = {64{1'b1}};
`ifdef HSKI_HEAP_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_RSP} state_t;

  state_t               r_state;
  logic                 r_req_ready;
  logic [64:0]          r_rsp;
  logic [HEAP_LOG2:0]   r_alloc_cnt;
  logic                 r_err;
  logic                 r_rd_oob;
  logic [63:0]          r_rd_data;
  logic [63:0]          r_mem [DEPTH];

  logic [1:0]           w_tag;
  logic [28:0]          w_addr;
  logic [63:0]          w_data;
  logic                 w_accept;
  logic                 w_full;
  logic                 w_addr_oob;
  logic                 w_mem_we;
  logic                 w_mem_re;
  logic [HEAP_LOG2-1:0] w_mem_idx;

  assign w_tag      = bus.req_i1[94:93];
  assign w_addr     = bus.req_i1[92:64];
  assign w_data     = bus.req_i1[63:0];
  assign w_accept   = r_req_ready && (w_tag != TAG_NONE);
  assign w_full     = (r_alloc_cnt >= DEPTH_CNT);
  // Without bounds checking the upper address bits simply wrap.
  assign w_addr_oob = BOUNDS_EN & (|w_addr[28:HEAP_LOG2]);

  // RAM port control: one access per accepted request.
  always_comb begin
    w_mem_we  = 1'b0;
    w_mem_re  = 1'b0;
    w_mem_idx = w_addr[HEAP_LOG2-1:0];
    if (w_accept) begin
      case (w_tag)
        TAG_RD:    w_mem_re = 1'b1;
        TAG_WR:    w_mem_we = !w_addr_oob;
        TAG_ALLOC: begin
          w_mem_we  = !w_full;
          w_mem_idx = r_alloc_cnt[HEAP_LOG2-1:0];
        end
        default:   w_mem_we = 1'b0;
      endcase
    end else begin
      w_mem_we = 1'b0;
    end
  end

  // Cell RAM with registered read port; contents are intentionally not reset.
  always_ff @(posedge system1000) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_data;
    end
    if (w_mem_re) begin
      r_rd_data <= r_mem[w_mem_idx];
    end
  end

  // Handshake FSM, allocation pointer and sticky error.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp       <= 65'd0;
      r_alloc_cnt <= ALLOC_BASE_CNT;
      r_err       <= 1'b0;
      r_rd_oob    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_tag)
              TAG_RD: begin
                r_state     <= ST_RD;
                r_req_ready <= 1'b0;
                r_rd_oob    <= w_addr_oob;
                r_err       <= r_err | w_addr_oob;
              end
              TAG_WR: begin
                r_err <= r_err | w_addr_oob;
              end
              TAG_ALLOC: begin
                r_state     <= ST_RSP;
                r_req_ready <= 1'b0;
                if (w_full) begin
                  r_rsp <= {1'b1, ALL_ONES};
                  r_err <= r_err | BOUNDS_EN;
                end else begin
                  r_rsp       <= {1'b1, 64'(r_alloc_cnt)};
                  r_alloc_cnt <= r_alloc_cnt + ONE_CNT;
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
        ST_RD: begin
          r_rsp   <= {1'b1, (r_rd_oob ? ALL_ONES : r_rd_data)};
          r_state <= ST_RSP;
        end
        ST_RSP: begin
          // Draining edge never accepts: ready rises only after it.
          if (bus.rsp_ready_i2) begin
            r_rsp[64]   <= 1'b0;
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp       <= 65'd0;
        end
      endcase
    end
  end

  assign bus.req_ready_o = r_req_ready;
  assign bus.rsp_o       = r_rsp;
  assign alloc_count_o   = r_alloc_cnt;
  assign err_o           = r_err;

endmodule

// File: tb/tb_hski_heap_responder.sv
// Self-checking bench for hski_heap_responder: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a behavioural heap model.
module tb_hski_heap_responder;
  localparam int HL    = 10;
  localparam int DEPTH = 1 << HL;
  localparam logic [1:0] T_RD = 2'b01;
  localparam logic [1:0] T_WR = 2'b10;
  localparam logic [1:0] T_AL = 2'b11;
  localparam logic [63:0] ONES = {64{1'b1}};
`ifdef HSKI_HEAP_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  hski_heap_responder_if bus();
  logic [HL:0] alloc_count;
  logic        err;

  hski_heap_responder #(.HEAP_LOG2(HL), .ALLOC_BASE(1)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .bus             (bus),
    .alloc_count_o   (alloc_count),
    .err_o           (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural heap: cell array, allocation pointer, sticky error.
  logic [63:0] m_mem [DEPTH];
  int          m_ptr = 1;
  bit          m_err = 1'b0;

  typedef struct {
    logic [1:0]  tag;
    logic [28:0] addr;
    logic [63:0] data;
    bit          exp_valid;
    logic [63:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_op(input logic [1:0] tag, input logic [28:0] addr,
                                           input logic [63:0] data, output bit has_rsp);
    int idx = int'(addr) % DEPTH;
    bit oob = BC && (int'(addr) >= DEPTH);
    logic [63:0] r = 64'd0;
    has_rsp = 1'b1;
    if (tag == T_RD) begin
      if (oob) begin m_err = 1'b1; r = ONES; end
      else r = m_mem[idx];
    end else if (tag == T_WR) begin
      has_rsp = 1'b0;
      if (oob) m_err = 1'b1;
      else m_mem[idx] = data;
    end else begin
      if (m_ptr < DEPTH) begin
        m_mem[m_ptr] = data;
        r = 64'(m_ptr);
        m_ptr++;
      end else begin
        if (BC) m_err = 1'b1;
        r = ONES;
      end
    end
    return r;
  endfunction

  task automatic send(input logic [1:0] tag, input logic [28:0] addr, input logic [63:0] data);
    int n = 0;
    @(negedge clk);
    bus.req_i1 = {tag, addr, data};
    while (bus.req_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: req_ready_o is %b, expected 1", bus.req_ready_o);
    end
    @(posedge clk);
    #1;
    bus.req_i1 = 95'd0;
  endtask

  task automatic drain(input string name);
    bus.rsp_ready_i2 = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready_i2 = 1'b0;
    check({name, "_drain_valid"}, 65'(bus.rsp_o[64]), 65'd0);
    check({name, "_drain_ready"}, 65'(bus.req_ready_o), 65'd1);
  endtask

  task automatic apply(input string name, input logic [1:0] tag, input logic [28:0] addr,
                       input logic [63:0] data, input bit exp_valid, input logic [63:0] exp_data,
                       input int hold);
    int lat;
    logic [64:0] held;
    send(tag, addr, data);
    if (exp_valid) begin
      lat = 1;
      while (bus.rsp_o[64] !== 1'b1 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check({name, "_lat"}, 65'(lat), (tag == T_RD) ? 65'd2 : 65'd1);
      check({name, "_rsp"}, bus.rsp_o, {1'b1, exp_data});
      check({name, "_busy"}, 65'(bus.req_ready_o), 65'd0);
      held = bus.rsp_o;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check({name, "_hold_rsp"}, bus.rsp_o, held);
        check({name, "_hold_busy"}, 65'(bus.req_ready_o), 65'd0);
      end
      drain(name);
    end else begin
      check({name, "_norsp"}, 65'(bus.rsp_o[64]), 65'd0);
      check({name, "_ready"}, 65'(bus.req_ready_o), 65'd1);
    end
  endtask

  initial begin
    vec_t vecs[$];
    logic [63:0] exp;
    bit has;
    logic [1:0] tag;
    logic [28:0] addr;
    logic [63:0] data;

    bus.req_i1 = 95'd0;
    bus.rsp_ready_i2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp",   bus.rsp_o, 65'd0);
    check("reset_ready", 65'(bus.req_ready_o), 65'd1);
    check("reset_alloc", 65'(alloc_count), 65'd1);
    check("reset_err",   65'(err), 65'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Directed vectors with hand-derived expectations.
    vecs.push_back('{T_WR, 29'd5,         64'h0123_4567_89AB_CDEF, 1'b0, 64'd0});
    vecs.push_back('{T_RD, 29'd5,         64'd0,  1'b1, 64'h0123_4567_89AB_CDEF});
    vecs.push_back('{T_AL, 29'd0,         64'hA,  1'b1, 64'd1});
    vecs.push_back('{T_AL, 29'd0,         64'hB,  1'b1, 64'd2});
    vecs.push_back('{T_AL, 29'd0,         64'hC,  1'b1, 64'd3});
    vecs.push_back('{T_RD, 29'd2,         64'd0,  1'b1, 64'hB});
    vecs.push_back('{T_RD, 29'd3,         64'd0,  1'b1, 64'hC});
    vecs.push_back('{T_RD, 29'd1,         64'd0,  1'b1, 64'hA});
    vecs.push_back('{T_WR, 29'd0,         64'h55, 1'b0, 64'd0});
    vecs.push_back('{T_WR, 29'h400,       64'h77, 1'b0, 64'd0});
    vecs.push_back('{T_RD, 29'd0,         64'd0,  1'b1, BC ? 64'h55 : 64'h77});
    vecs.push_back('{T_RD, 29'h400,       64'd0,  1'b1, BC ? ONES : 64'h77});
    vecs.push_back('{T_WR, 29'h3FF,       64'h99, 1'b0, 64'd0});
    vecs.push_back('{T_RD, 29'h3FF,       64'd0,  1'b1, 64'h99});
    vecs.push_back('{T_RD, 29'h1FFF_FFFF, 64'd0,  1'b1, BC ? ONES : 64'h99});
    foreach (vecs[i]) begin
      exp = model_op(vecs[i].tag, vecs[i].addr, vecs[i].data, has);
      apply($sformatf("vec%0d", i), vecs[i].tag, vecs[i].addr, vecs[i].data,
            vecs[i].exp_valid, vecs[i].exp_data, 0);
    end
    check("vec_alloc_count", 65'(alloc_count), 65'd4);
    check("vec_err", 65'(err), 65'(BC));

    // Response held for 10 cycles under back-pressure.
    exp = model_op(T_RD, 29'd5, 64'd0, has);
    apply("hold", T_RD, 29'd5, 64'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 10);

    // Back-to-back writes, then a read accepted on the edge right after a write.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.req_i1 = {T_WR, 29'(40 + i), 64'(64'h1000 + i)};
      exp = model_op(T_WR, 29'(40 + i), 64'(64'h1000 + i), has);
      @(posedge clk);
      #1;
      check("b2b_ready", 65'(bus.req_ready_o), 65'd1);
    end
    bus.req_i1 = {T_WR, 29'd50, 64'hDEAD_BEEF};
    exp = model_op(T_WR, 29'd50, 64'hDEAD_BEEF, has);
    @(posedge clk);
    #1;
    bus.req_i1 = 95'd0;
    exp = model_op(T_RD, 29'd50, 64'd0, has);
    apply("wr_then_rd", T_RD, 29'd50, 64'd0, 1'b1, 64'hDEAD_BEEF, 0);
    for (int i = 0; i < 4; i++) begin
      exp = model_op(T_RD, 29'(40 + i), 64'd0, has);
      apply("b2b_read", T_RD, 29'(40 + i), 64'd0, 1'b1, 64'(64'h1000 + i), 0);
    end

    // Random traffic against the model; cells 0..31 are initialised first.
    for (int i = 0; i < 32; i++) begin
      data = {$urandom, $urandom};
      exp = model_op(T_WR, 29'(i), data, has);
      apply("init", T_WR, 29'(i), data, has, exp, 0);
    end
    for (int k = 0; k < 300; k++) begin
      tag  = 2'($urandom_range(3, 1));
      addr = {(($urandom_range(3, 0) == 0) ? 19'($urandom) : 19'd0), 10'($urandom_range(31, 0))};
      data = {$urandom, $urandom};
      exp = model_op(tag, addr, data, has);
      apply("rand", tag, addr, data, has, exp, $urandom_range(3, 0));
      check("rand_alloc_count", 65'(alloc_count), 65'(m_ptr));
      check("rand_err", 65'(err), 65'(m_err));
    end

    // Fill the heap, then allocate past the end.
    while (m_ptr < DEPTH) begin
      data = {$urandom, $urandom};
      exp = model_op(T_AL, 29'd0, data, has);
      apply("fill", T_AL, 29'd0, data, 1'b1, exp, 0);
    end
    for (int i = 0; i < 2; i++) begin
      exp = model_op(T_AL, 29'd0, 64'h5A5A, has);
      apply("full", T_AL, 29'd0, 64'h5A5A, 1'b1, ONES, 0);
      check("full_alloc_count", 65'(alloc_count), 65'(DEPTH));
      check("full_err", 65'(err), 65'(BC));
    end

    // Reset while a read is in flight discards it; RAM contents survive.
    send(T_RD, 29'd5, 64'd0);
    rstn = 1'b0;
    #1;
    check("rst_rd_rsp",   bus.rsp_o, 65'd0);
    check("rst_rd_ready", 65'(bus.req_ready_o), 65'd1);
    check("rst_rd_alloc", 65'(alloc_count), 65'd1);
    check("rst_rd_err",   65'(err), 65'd0);
    m_ptr = 1;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_rsp", 65'(bus.rsp_o[64]), 65'd0);
    end
    check("rst_alloc_after", 65'(alloc_count), 65'd1);
    exp = model_op(T_RD, 29'd5, 64'd0, has);
    apply("post_rst_rd", T_RD, 29'd5, 64'd0, 1'b1, exp, 0);
    exp = model_op(T_AL, 29'd0, 64'hF00D, has);
    apply("post_rst_al", T_AL, 29'd0, 64'hF00D, 1'b1, 64'd1, 0);
    check("post_rst_alloc_count", 65'(alloc_count), 65'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hski_heap_responder.md
# hski_heap_responder

Heap memory responder for the SKI reduction core. It services the packed cell requests the step logic emits: read, write and allocate on a single-port cell RAM, with a registered response and a valid/ready back-pressure handshake. It sits between the reduction step pipeline and on-chip heap storage, and it is the only owner of the heap allocation pointer.

## Interface
Parameters:
- HEAP_LOG2, 10, log2 of heap depth in 64-bit cells.
- ALLOC_BASE, 1, first address handed out by allocate. Address 0 is reserved as nil.

Ports:
- system1000  in  1  clock, rising edge.
- system1000_rstn  in  1  reset, asynchronous, active-low.
- req_i1  in  95  request: tag [94:93], addr [92:64], data [63:0]. Tags: 00 none, 01 read, 10 write, 11 allocate.
- req_ready_o  out  1  responder can accept a request this cycle.
- rsp_o  out  65  response: valid [64], data [63:0].
- rsp_ready_i2  in  1  consumer accepts the response this cycle.
- alloc_count_o  out  HEAP_LOG2+1  next allocation address; holds 2^HEAP_LOG2 when the heap is full.
- err_o  out  1  sticky error flag. Active only with the bounds-check macro defined.

## Operation
- A request is accepted on an edge where tag != 00 and req_ready_o = 1. When tag = 00, data and addr are ignored.
- The FSM has three states: IDLE, RD, RSP. req_ready_o = (state == IDLE).
- Write:
  - Commits data to RAM[addr] at the accept edge.
  - The FSM stays in IDLE, so back-to-back writes run at one per cycle.
  - No response is generated.
- Read:
  - The accept edge issues the RAM read and moves the FSM IDLE→RD.
  - The next edge loads rsp_o = {1, RAM data} and moves RD→RSP.
- Allocate:
  - When alloc_count_o < 2^HEAP_LOG2:
    - RAM[alloc_count_o] is written with data.
    - rsp_o = {1, zero-extended old alloc_count_o}.
    - alloc_count_o increments by 1.
    - The FSM moves IDLE→RSP in one edge.
  - When the heap is full: rsp_o = {1, 64'hFFFF_FFFF_FFFF_FFFF}, no RAM write, and the pointer is unchanged.
- RSP state:
  - rsp_o stays stable until an edge with rsp_ready_i2 = 1.
  - That edge clears rsp_o[64] and moves the FSM RSP→IDLE.
  - A new request is never accepted on the same edge that a response drains.
- Addressing: without bounds checking, RAM index = addr[HEAP_LOG2-1:0], so upper address bits wrap modulo the depth.
- The allocation pointer never wraps and never decrements. There is no free operation; garbage collection is outside this block.
- Reset:
  - state = IDLE.
  - rsp_o = 65'b0, so req_ready_o = 1.
  - alloc_count_o = ALLOC_BASE.
  - err_o = 0.
  - RAM contents are not reset.
  - Reset asserted mid-read or mid-response discards the pending response. No partial response is ever presented.

## Timing
- Write: 1 edge to commit. The data is readable by a read accepted on the next edge.
- Read: response valid 2 edges after accept.
- Allocate: response valid 1 edge after accept.
- Throughput:
  - Writes: 1 per cycle.
  - Read with rsp_ready_i2 held high: 1 per 3 cycles.
  - Allocate with rsp_ready_i2 held high: 1 per 2 cycles.
- rsp_o, req_ready_o, alloc_count_o and err_o are all driven directly from registers. There is no combinational path from req_i1 or rsp_ready_i2 to any output.
- req_i1 must be held by the sender until accepted. rsp_ready_i2 may toggle freely.

## Configuration
- HSKI_HEAP_BOUNDS_CHECK_EN defined:
  - A read or write with addr[28:HEAP_LOG2] != 0 is out of range.
  - An out-of-range write is dropped.
  - An out-of-range read returns all-ones data.
  - Either case sets err_o, which stays 1 until reset.
  - Allocate on a full heap also sets err_o.
- HSKI_HEAP_BOUNDS_CHECK_EN undefined:
  - Addresses wrap as described under Operation.
  - err_o is constant 0.
  - Full-heap allocate still returns all-ones.

## Test plan
- Reset, then write addr 5 data 0x0123_4567_89AB_CDEF, then read addr 5 → rsp_o = {1, 0x0123456789ABCDEF} exactly 2 edges after the read accept; req_ready_o low during RD/RSP.
- Three allocates with data 0xA, 0xB, 0xC and rsp_ready_i2 = 1 → responses 1, 2, 3; alloc_count_o = 4; reads of addr 2 and addr 3 return 0xB and 0xC.
- Hold rsp_ready_i2 = 0 for 10 cycles after a read → rsp_o stable, req_ready_o = 0 throughout; raise rsp_ready_i2 → valid drops on that edge and req_ready_o = 1 the next cycle.
- With HEAP_LOG2 = 2 and ALLOC_BASE = 1, four allocates → responses 1, 2, 3, then all-ones; alloc_count_o = 4 and stays 4.
- With HEAP_LOG2 = 10, write addr 0x400 data 0x77 → without the macro, a read of addr 0 returns 0x77; with the macro, the write is dropped, err_o = 1, and a read of addr 0x400 returns all-ones.
- Assert system1000_rstn low while in RD → rsp_o = 0, req_ready_o = 1, and alloc_count_o = ALLOC_BASE after release; no response appears.
